// File: rtl/threshold_cutter_pkg.sv
// threshold_cutter_pkg: geometry, tag constant, address/tag helpers and reader FSM states shared by the capture writer and reader.
package threshold_cutter_pkg;
  localparam int WINDOW_DEPTH = 100;
  localparam int BLOCK_DEPTH = WINDOW_DEPTH * 4;
  localparam int BLOCK_DEPTH_INDEX = 9;
  localparam int BLOCK_NUM_INDEX = 4;
  localparam int WORD_W = 256;
  localparam logic [127:0] PRESET_SEQUENCE = 128'h00_01_02_03_04_05_06_07_08_09_00_01_02_03_04_05;
  typedef enum logic [2:0] {IDLE, AR_DATA, R_DATA, AR_TAG, R_TAG, DONE} rd_state_e;
  function automatic logic [31:0] word_addr(input logic [BLOCK_NUM_INDEX-1:0] b, input logic [BLOCK_DEPTH_INDEX-1:0] w);
    return 32'({b, w, 5'b0});
  endfunction
  // The tag is one bit of the preset constant selected by block number, zero-extended.
  function automatic logic [WORD_W-1:0] tag_word(input logic [127:0] seq, input logic [BLOCK_NUM_INDEX-1:0] b);
    return WORD_W'(seq[b]);
  endfunction
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single-entry valid/ready output register; accepts a new word whenever empty or draining.
module axis_reg_slice #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] s_data_i,
  input  logic         s_last_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_last_o,
  output logic         m_valid_o,
  input  logic         m_ready_i
);
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d, valid_q, valid_d, load;
  assign s_ready_o = !valid_q | m_ready_i;
  assign load = s_valid_i & s_ready_o;
  always_comb begin
    data_d = load ? s_data_i : data_q;
    last_d = load ? s_last_i : last_q;
    valid_d = load | (valid_q & !m_ready_i);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q <= data_d;
      last_q <= last_d;
      valid_q <= valid_d;
    end
  end
  assign m_data_o = data_q;
  assign m_last_o = last_q;
  assign m_valid_o = valid_q;
endmodule

// File: rtl/threshold_block_reader.sv
// threshold_block_reader: AXI4 read master draining finished capture blocks to a stream and checking each block's tag word.
module threshold_block_reader
  import threshold_cutter_pkg::*;
#(
  parameter int           WINDOW_DEPTH      = threshold_cutter_pkg::WINDOW_DEPTH,
  parameter int           BLOCK_DEPTH_INDEX = threshold_cutter_pkg::BLOCK_DEPTH_INDEX,
  parameter int           BLOCK_NUM_INDEX   = threshold_cutter_pkg::BLOCK_NUM_INDEX,
  parameter int           BURST_LEN         = 16,
  parameter logic [127:0] PRESET_SEQUENCE   = threshold_cutter_pkg::PRESET_SEQUENCE,
  parameter logic [3:0]   AXI_ID            = 4'd1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BLOCK_NUM_INDEX-1:0] wr_block_no,
  output logic [3:0]                 m_axi_arid,
  output logic [31:0]                m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [3:0]                 m_axi_rid,
  input  logic [255:0]               m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  output logic [255:0]               m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       m_last,
  output logic                       blk_done,
  output logic                       blk_ok,
  output logic [BLOCK_NUM_INDEX-1:0] blk_no,
  output logic [BLOCK_NUM_INDEX-1:0] rd_block_no
);
  localparam int BD = WINDOW_DEPTH * 4;
  if (BD % BURST_LEN != 0 || BURST_LEN > 256 || BURST_LEN < 1) begin : g_bad_burst
    $error("BURST_LEN must divide BLOCK_DEPTH and lie in 1..256");
  end
  rd_state_e                  state_q, state_d;
  logic [BLOCK_DEPTH_INDEX-1:0] word_idx_q, word_idx_d;
  logic [BLOCK_NUM_INDEX-1:0] rd_q, rd_d, blk_no_q, blk_no_d;
  logic resp_err_q, resp_err_d, tag_err_q, tag_err_d;
  logic blk_done_q, blk_done_d, blk_ok_q, blk_ok_d;
  logic slice_ready, beat, rerr, tag_bad, last_word;
  assign m_axi_arid = AXI_ID;
  assign m_axi_arsize = 3'b101;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state_q == AR_DATA) | (state_q == AR_TAG);
  assign m_axi_araddr = word_addr(rd_q, state_q == AR_TAG ? BLOCK_DEPTH_INDEX'(BD) : word_idx_q);
  assign m_axi_arlen = state_q == AR_DATA ? 8'(BURST_LEN - 1) : 8'd0;
  assign m_axi_rready = state_q == R_DATA ? slice_ready : state_q == R_TAG;
  assign beat = m_axi_rvalid & m_axi_rready;
  assign rerr = m_axi_rresp != 2'b00;
  assign tag_bad = m_axi_rdata != tag_word(PRESET_SEQUENCE, rd_q);
  assign last_word = word_idx_q == BLOCK_DEPTH_INDEX'(BD - 1);
  always_comb begin
    state_d = state_q;
    word_idx_d = word_idx_q;
    rd_d = rd_q;
    resp_err_d = resp_err_q;
    tag_err_d = tag_err_q;
    blk_done_d = 1'b0;
    blk_ok_d = blk_ok_q;
    blk_no_d = blk_no_q;
    case (state_q)
      IDLE: if (rd_q != wr_block_no) begin
        word_idx_d = '0;
        resp_err_d = 1'b0;
        tag_err_d = 1'b0;
        state_d = AR_DATA;
      end
      AR_DATA: state_d = m_axi_arready ? R_DATA : AR_DATA;
      R_DATA: if (beat) begin
        word_idx_d = word_idx_q + 1'b1;
        resp_err_d = resp_err_q | rerr;
        state_d = !m_axi_rlast ? R_DATA : last_word ? AR_TAG : AR_DATA;
      end
      AR_TAG: state_d = m_axi_arready ? R_TAG : AR_TAG;
      R_TAG: if (m_axi_rvalid) begin
        // Status and pointer advance register on the tag beat so both appear together in DONE.
        resp_err_d = resp_err_q | rerr;
        tag_err_d = tag_bad;
        blk_done_d = 1'b1;
        blk_ok_d = !(resp_err_q | rerr | tag_bad);
        blk_no_d = rd_q;
        rd_d = rd_q + 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_idx_q <= '0;
      rd_q <= '0;
      resp_err_q <= 1'b0;
      tag_err_q <= 1'b0;
      blk_done_q <= 1'b0;
      blk_ok_q <= 1'b0;
      blk_no_q <= '0;
    end else begin
      state_q <= state_d;
      word_idx_q <= word_idx_d;
      rd_q <= rd_d;
      resp_err_q <= resp_err_d;
      tag_err_q <= tag_err_d;
      blk_done_q <= blk_done_d;
      blk_ok_q <= blk_ok_d;
      blk_no_q <= blk_no_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && beat) begin
      assert (m_axi_rid == AXI_ID) else $error("unexpected RID %0h", m_axi_rid);
      if (state_q == R_DATA)
        assert (m_axi_rlast == ((int'(word_idx_q) + 1) % BURST_LEN == 0)) else $error("RLAST off burst boundary");
      else
        assert (m_axi_rlast) else $error("tag beat without RLAST");
    end
  end
  axis_reg_slice #(.W(256)) u_out (
    .clk(clk),
    .rst_n(rst_n),
    .s_data_i(m_axi_rdata),
    .s_last_i(last_word),
    .s_valid_i(m_axi_rvalid & (state_q == R_DATA)),
    .s_ready_o(slice_ready),
    .m_data_o(m_data),
    .m_last_o(m_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready)
  );
  assign blk_done = blk_done_q;
  assign blk_ok = blk_ok_q;
  assign blk_no = blk_no_q;
  assign rd_block_no = rd_q;
endmodule

// File: tb/tb_threshold_block_reader.sv
// tb_threshold_block_reader: randomized AXI slave and stream sink with queue-based scoreboard for the block reader.
module tb_threshold_block_reader;
  localparam logic [127:0] PS = 128'h00_01_02_03_04_05_06_07_08_09_00_01_02_03_04_05;
  localparam int BD = 400;
  logic clk = 0, rst_n = 0;
  logic [3:0] wr_block_no = 0;
  logic [3:0] arid, rid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst, rresp;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [255:0] rdata, m_data;
  logic m_valid, m_ready, m_last, blk_done, blk_ok;
  logic [3:0] blk_no, rd_block_no;
  int checks = 0, errors = 0, words_rx = 0, ready_pct = 100, rd_m = 0;
  int err_beat[16];
  bit bad_tag[16];
  logic [39:0] arq[$];
  logic [256:0] wq[$];
  logic [4:0] dq[$];

  threshold_block_reader dut (
    .clk(clk), .rst_n(rst_n), .wr_block_no(wr_block_no),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .blk_done(blk_done), .blk_ok(blk_ok), .blk_no(blk_no), .rd_block_no(rd_block_no)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents: data words hold their own byte address; the tag word holds the preset bit, or its inverse when corrupted.
  function automatic logic [255:0] mem_word(input logic [31:0] a);
    int b = int'(a[17:14]);
    int w = int'(a[13:5]);
    if (w == BD) return bad_tag[b] ? 256'(!PS[b]) : 256'(PS[b]);
    return 256'(a);
  endfunction

  initial begin
    logic s_rst, s_ar, s_r;
    logic [31:0] s_addr, baddr;
    logic [7:0] s_len;
    int left;
    left = 0; baddr = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 4'd1;
    forever begin
      @(negedge clk);
      s_rst = !rst_n; s_ar = arvalid && arready; s_r = rvalid && rready;
      s_addr = araddr; s_len = arlen;
      @(posedge clk); #1;
      if (s_rst) begin
        left = 0; rvalid = 0; arready = 0;
      end else begin
        if (s_r) begin left--; baddr += 32; end
        if (s_ar) begin baddr = s_addr; left = int'(s_len) + 1; end
        if (!(rvalid && !s_r)) rvalid = left > 0 && $urandom_range(3) != 0;
        rdata = mem_word(baddr);
        rresp = int'(baddr[13:5]) == err_beat[baddr[17:14]] ? 2'b10 : 2'b00;
        rlast = left == 1;
        arready = 1'($urandom_range(1));
      end
    end
  end

  initial begin
    m_ready = 0;
    forever begin
      @(posedge clk); #1;
      m_ready = $urandom_range(99) < ready_pct;
    end
  end

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      words_rx++;
      if (wq.size() == 0) chk("unexpected_word", {m_last, m_data}, 257'h0);
      else chk("word", {m_last, m_data}, wq.pop_front());
    end
    if (rst_n && arvalid && arready) begin
      if (arq.size() == 0) chk("unexpected_ar", {araddr, arlen}, 40'h0);
      else chk("ar", {araddr, arlen}, arq.pop_front());
    end
    if (rst_n && m_valid && !m_ready) chk("rready_backpressure", rready, 0);
    if (blk_done) begin
      if (dq.size() == 0) chk("unexpected_done", {blk_no, blk_ok}, 5'h1f);
      else begin
        logic [4:0] e;
        e = dq.pop_front();
        chk("done", {blk_no, blk_ok}, e);
        chk("ptr_at_done", rd_block_no, 4'(e[4:1] + 1));
      end
    end
  end

  task automatic issue(input int nw);
    while (rd_m != nw) begin
      for (int i = 0; i < BD / 16; i++) arq.push_back({32'((rd_m << 14) + i * 16 * 32), 8'd15});
      arq.push_back({32'((rd_m << 14) + BD * 32), 8'd0});
      for (int w = 0; w < BD; w++) wq.push_back({w == BD - 1, 256'((rd_m << 14) + w * 32)});
      dq.push_back({4'(rd_m), !bad_tag[rd_m] && err_beat[rd_m] < 0});
      rd_m = (rd_m + 1) % 16;
    end
    wr_block_no = 4'(nw);
  endtask

  task automatic drain();
    int n = 0;
    while ((wq.size() != 0 || arq.size() != 0 || dq.size() != 0) && n < 30000) begin
      @(posedge clk); n++;
    end
    if (n >= 30000) chk("drain_timeout", 1, 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_rready", rready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_blk_done", blk_done, 0);
    chk("rst_blk_ok", blk_ok, 0);
    chk("rst_blk_no", blk_no, 0);
    chk("rst_rd_block_no", rd_block_no, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin err_beat[i] = -1; bad_tag[i] = 0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    chk("arid", arid, 4'd1);
    chk("arsize", arsize, 3'b101);
    chk("arburst", arburst, 2'b01);
    @(posedge clk); #1;
    rst_n = 1;
    issue(1);
    drain();
    chk("ptr_blk0", rd_block_no, 4'd1);
    ready_pct = 30;
    bad_tag[1] = 1;
    issue(2);
    drain();
    chk("ptr_badtag", rd_block_no, 4'd2);
    err_beat[2] = 37;
    issue(3);
    drain();
    chk("ptr_slverr", rd_block_no, 4'd3);
    ready_pct = 100;
    issue(15);
    drain();
    chk("ptr_15", rd_block_no, 4'd15);
    ready_pct = 70;
    issue(1);
    drain();
    chk("ptr_wrap", rd_block_no, 4'd1);
    for (int i = 0; i < 16; i++) begin err_beat[i] = -1; bad_tag[i] = 0; end
    begin
      int w0 = words_rx, n = 0;
      issue(2);
      while (!(words_rx >= w0 + 50 && rready) && n < 5000) begin
        @(posedge clk); #2; n++;
      end
      if (n >= 5000) chk("reset_wait_timeout", 1, 0);
    end
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    wq.delete(); arq.delete(); dq.delete();
    rd_m = 0;
    issue(2);
    @(negedge clk);
    chk_reset_outputs();
    drain();
    chk("ptr_after_reread", rd_block_no, 4'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
